// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter/sequencer sharing one single-ported data memory
module dm_arbiter #(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int DEPTH     = 512,
   parameter int PRIO_MODE = 0,
   parameter int MAX_WAIT  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_gnt,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_gnt,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] dm_addr,
   output logic              dm_re,
   output logic              dm_we,
   output logic [DATA_W-1:0] dm_wrt_data,
   input  logic [DATA_W-1:0] dm_rd_data,
   output logic              err_oob
);
   localparam int CW = $clog2(MAX_WAIT + 2);
   logic              rr_q, rr_d;
   logic [CW-1:0]     wait_q, wait_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              re_q, re_d, we_q, we_d, own_q, own_d, pend_q, pend_d, err_q, err_d;
   logic              in0, in1, pick1, any, win_we, win_in;
   // Arbitration and next-state for the issue registers; rr_q=1 means port 1 is preferred
   always_comb begin
      in0     = 32'(p0_addr) < 32'(DEPTH);
      in1     = 32'(p1_addr) < 32'(DEPTH);
      pick1   = (PRIO_MODE != 0) ? (wait_q == CW'(MAX_WAIT)) : rr_q;
      p1_gnt  = rst_n & p1_req & (~p0_req | pick1);
      p0_gnt  = rst_n & p0_req & ~p1_gnt;
      any     = p0_gnt | p1_gnt;
      win_we  = p1_gnt ? p1_we : p0_we;
      win_in  = p1_gnt ? in1 : in0;
      rr_d    = (p0_req & p1_req & any) ? p0_gnt : rr_q;
      wait_d  = p1_gnt ? '0 : (p1_req && wait_q != CW'(MAX_WAIT)) ? wait_q + CW'(1) : wait_q;
      addr_d  = p1_gnt ? p1_addr : p0_gnt ? p0_addr : addr_q;
      wdata_d = p1_gnt ? p1_wdata : p0_gnt ? p0_wdata : wdata_q;
      re_d    = any & ~win_we & win_in;
      we_d    = any & win_we & win_in;
      own_d   = any ? p1_gnt : own_q;
      pend_d  = any & ~win_we;
      err_d   = any & ~win_in;
   end
   // Issue registers with synchronous active-low reset; a reset drops any pending read
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_q    <= 1'b0;
         wait_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
         own_q   <= 1'b0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         rr_q    <= rr_d;
         wait_q  <= wait_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         re_q    <= re_d;
         we_q    <= we_d;
         own_q   <= own_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
      end
   end
   assign dm_addr     = addr_q;
   assign dm_wrt_data = wdata_q;
   assign dm_re       = re_q;
   assign dm_we       = we_q;
   assign err_oob     = err_q;
   assign p0_rvalid   = pend_q & ~own_q;
   assign p1_rvalid   = pend_q & own_q;
   assign p0_rdata    = (~own_q & ~err_q) ? dm_rd_data : '0;
   assign p1_rdata    = (own_q & ~err_q) ? dm_rd_data : '0;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: table-driven check of dm_arbiter (round-robin) plus priority/starvation and reset sequences
module tb_dm_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
   logic [15:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
   logic a_g0, a_g1, a_v0, a_v1, a_re, a_we, a_err;
   logic [15:0] a_rd0, a_rd1, a_addr, a_wd;
   logic [15:0] a_mrd = 16'h0;
   logic b_g0, b_g1, b_v0, b_v1, b_re, b_we, b_err;
   logic [15:0] b_rd0, b_rd1, b_addr, b_wd;
   logic [15:0] b_mrd = 16'h0;
   logic [15:0] mem_a [512];
   logic [15:0] mem_b [512];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dm_arbiter #(.PRIO_MODE(0)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(a_g0), .p0_rvalid(a_v0), .p0_rdata(a_rd0),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(a_g1), .p1_rvalid(a_v1), .p1_rdata(a_rd1),
      .dm_addr(a_addr), .dm_re(a_re), .dm_we(a_we), .dm_wrt_data(a_wd),
      .dm_rd_data(a_mrd), .err_oob(a_err));

   dm_arbiter #(.PRIO_MODE(1), .MAX_WAIT(4)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(b_g0), .p0_rvalid(b_v0), .p0_rdata(b_rd0),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(b_g1), .p1_rvalid(b_v1), .p1_rdata(b_rd1),
      .dm_addr(b_addr), .dm_re(b_re), .dm_we(b_we), .dm_wrt_data(b_wd),
      .dm_rd_data(b_mrd), .err_oob(b_err));

   // Memory models act on the falling edge, as the real data memory does
   always @(negedge clk) begin
      if (a_we) mem_a[a_addr[8:0]] <= a_wd;
      if (a_re) a_mrd <= mem_a[a_addr[8:0]];
      if (b_we) mem_b[b_addr[8:0]] <= b_wd;
      if (b_re) b_mrd <= mem_b[b_addr[8:0]];
   end

   // re and we must never be asserted together
   always @(negedge clk) begin
      checks++;
      if (((a_re & a_we) | (b_re & b_we)) !== 1'b0) begin
         errors++;
         $display("FAIL re_we_excl at %0t: a=%b%b b=%b%b required no overlap", $time, a_re, a_we, b_re, b_we);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic r0, input logic w0, input logic [15:0] a0, input logic [15:0] d0,
                        input logic r1, input logic w1, input logic [15:0] a1, input logic [15:0] d1);
      @(posedge clk);
      #1;
      rst_n = rst;
      p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
      p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
      #6;
   endtask

   typedef struct {
      logic rst, r0, w0; logic [15:0] a0, d0;
      logic r1, w1; logic [15:0] a1, d1;
      logic g0, g1, re, we; logic [15:0] ad, wd;
      logic err, v0; logic [15:0] rd0;
      logic v1; logic [15:0] rd1;
   } vec_t;

   vec_t v [15];

   initial begin
      for (int i = 0; i < 512; i++) begin
         mem_a[i] = 16'h0;
         mem_b[i] = 16'h0;
      end
      mem_a[16] = 16'hBEEF;
      mem_b[16] = 16'hBEEF;
      //        rst r0 w0 a0       d0       r1 w1 a1       d1        g0 g1 re we ad       wd       err v0 rd0      v1 rd1
      v[0]  = '{0, 1, 0, 16'h010, 16'h0000, 0, 0, 16'h000, 16'h0000, 0, 0, 0, 0, 16'h000, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000};
      v[1]  = '{1, 1, 0, 16'h010, 16'h0000, 0, 0, 16'h000, 16'h0000, 1, 0, 0, 0, 16'h000, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000};
      v[2]  = '{1, 0, 0, 16'h000, 16'h0000, 0, 0, 16'h000, 16'h0000, 0, 0, 1, 0, 16'h010, 16'h0000, 0, 1, 16'hBEEF, 0, 16'h0000};
      v[3]  = '{1, 0, 0, 16'h000, 16'h0000, 1, 1, 16'h1FF, 16'h1234, 0, 1, 0, 0, 16'h010, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000};
      v[4]  = '{1, 0, 0, 16'h000, 16'h0000, 1, 0, 16'h1FF, 16'h0000, 0, 1, 0, 1, 16'h1FF, 16'h1234, 0, 0, 16'h0000, 0, 16'h0000};
      v[5]  = '{1, 0, 0, 16'h000, 16'h0000, 0, 0, 16'h000, 16'h0000, 0, 0, 1, 0, 16'h1FF, 16'h0000, 0, 0, 16'h0000, 1, 16'h1234};
      v[6]  = '{1, 1, 0, 16'h010, 16'h0000, 1, 0, 16'h1FF, 16'h0000, 1, 0, 0, 0, 16'h1FF, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000};
      v[7]  = '{1, 1, 0, 16'h010, 16'h0000, 1, 0, 16'h1FF, 16'h0000, 0, 1, 1, 0, 16'h010, 16'h0000, 0, 1, 16'hBEEF, 0, 16'h0000};
      v[8]  = '{1, 1, 0, 16'h010, 16'h0000, 1, 0, 16'h1FF, 16'h0000, 1, 0, 1, 0, 16'h1FF, 16'h0000, 0, 0, 16'h0000, 1, 16'h1234};
      v[9]  = '{1, 1, 0, 16'h010, 16'h0000, 1, 0, 16'h1FF, 16'h0000, 0, 1, 1, 0, 16'h010, 16'h0000, 0, 1, 16'hBEEF, 0, 16'h0000};
      v[10] = '{1, 0, 0, 16'h000, 16'h0000, 0, 0, 16'h000, 16'h0000, 0, 0, 1, 0, 16'h1FF, 16'h0000, 0, 0, 16'h0000, 1, 16'h1234};
      v[11] = '{1, 1, 0, 16'h200, 16'h0000, 0, 0, 16'h000, 16'h0000, 1, 0, 0, 0, 16'h1FF, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000};
      v[12] = '{1, 1, 1, 16'h300, 16'h5555, 0, 0, 16'h000, 16'h0000, 1, 0, 0, 0, 16'h200, 16'h0000, 1, 1, 16'h0000, 0, 16'h0000};
      v[13] = '{1, 1, 0, 16'h100, 16'h0000, 0, 0, 16'h000, 16'h0000, 1, 0, 0, 0, 16'h300, 16'h5555, 1, 0, 16'h0000, 0, 16'h0000};
      v[14] = '{1, 0, 0, 16'h000, 16'h0000, 0, 0, 16'h000, 16'h0000, 0, 0, 1, 0, 16'h100, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000};
      for (int i = 0; i < 15; i++) begin
         drive(v[i].rst, v[i].r0, v[i].w0, v[i].a0, v[i].d0, v[i].r1, v[i].w1, v[i].a1, v[i].d1);
         chk($sformatf("v%0d_gnt", i), {a_g0, a_g1}, {v[i].g0, v[i].g1});
         chk($sformatf("v%0d_re_we", i), {a_re, a_we}, {v[i].re, v[i].we});
         chk($sformatf("v%0d_addr", i), a_addr, v[i].ad);
         chk($sformatf("v%0d_wdata", i), a_wd, v[i].wd);
         chk($sformatf("v%0d_err", i), a_err, v[i].err);
         chk($sformatf("v%0d_rvalid", i), {a_v0, a_v1}, {v[i].v0, v[i].v1});
         if (v[i].v0 | v[i].v1) begin
            chk($sformatf("v%0d_rdata0", i), a_rd0, v[i].rd0);
            chk($sformatf("v%0d_rdata1", i), a_rd1, v[i].rd1);
         end
      end
      chk("oob_mem_untouched", mem_a[256], 16'h0000);
      // Reset in the cycle after a granted p1 read
      drive(1, 0, 0, 16'h0, 16'h0, 1, 0, 16'h1FF, 16'h0);
      chk("rst_rd_gnt", {a_g0, a_g1}, 2'b01);
      drive(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h1FF, 16'h0);
      chk("rst_gnt_forced", {a_g0, a_g1, b_g0, b_g1}, 4'b0000);
      chk("rst_rd_inflight", {a_re, a_v1, a_rd1}, {1'b1, 1'b1, 16'h1234});
      drive(1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
      chk("rst_rvalid_dropped", {a_v0, a_v1}, 2'b00);
      chk("rst_dm_cleared", {a_re, a_we, a_err, a_addr, a_wd}, 35'h0);
      // Fixed priority with starvation guard: p0 wins four times, then p1 once
      for (int c = 0; c < 7; c++) begin
         drive(1, 1, 0, 16'h010, 16'h0, 1, 0, 16'h1FF, 16'h0);
         chk($sformatf("starve_c%0d", c), {b_g0, b_g1}, (c == 4) ? 2'b01 : 2'b10);
      end
      drive(1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
      chk("starve_tail_owner", {b_v0, b_v1, b_rd0}, {1'b1, 1'b0, 16'hBEEF});
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
